// File: rtl/sram_uart_dumper_pkg.sv
// ============================================================================
// Module      : sram_uart_dumper_pkg
// Description : Shared types and defaults for the SRAM dumper and loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sram_uart_dumper_pkg;

    localparam int c_ADDR_W         = 5;
    localparam int c_DATA_W         = 32;
    localparam int c_BYTES_PER_WORD = c_DATA_W / 8;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_REQ  = 3'd1,
        S_RD_WAIT = 3'd2,
        S_LOAD    = 3'd3,
        S_SEND    = 3'd4,
        S_FINISH  = 3'd5
    } dump_state_t;

    function automatic int bytes_per_word(input int data_w);
        return data_w / 8;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sram_uart_dumper.sv
// ============================================================================
// Module      : sram_uart_dumper
// Description : Streams a range of SRAM words out over the UART TX, byte-serial.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_uart_dumper
    import sram_uart_dumper_pkg::*;
#(
    parameter int ADDR_W    = c_ADDR_W,
    parameter int DATA_W    = c_DATA_W,
    parameter int SRAM_LAT  = 1,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    output logic              busy,
    output logic              done,
    output logic              csb_n,
    output logic              we_n,
    output logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] sram_data_out,
    output logic              tx_enable,
    output logic              tx_valid,
    output logic [7:0]        tx_data_in,
    input  logic              tx_ready
);

    localparam int              c_NBYTES = bytes_per_word(DATA_W);
    localparam int              c_IDX_W  = (c_NBYTES > 1) ? $clog2(c_NBYTES) : 1;
    localparam logic [ADDR_W:0] c_ONE    = (ADDR_W+1)'(1);

    dump_state_t          r_state;
    dump_state_t          w_next;
    logic [ADDR_W-1:0]    r_addr;
    logic [ADDR_W:0]      r_remain;
    logic [DATA_W-1:0]    r_shift;
    logic [c_IDX_W-1:0]   r_byte_idx;
    logic [1:0]           r_wait;

    logic                 w_xfer;
    logic                 w_last_byte;
    logic                 w_word_done;
    logic                 w_wait_done;
    logic [7:0]           w_cur_byte;
    logic [DATA_W-1:0]    w_shift_nxt;

    assign w_xfer      = (r_state == S_SEND) && tx_ready;
    assign w_last_byte = (r_byte_idx == c_IDX_W'(c_NBYTES - 1));
    assign w_word_done = w_xfer && w_last_byte;
    // RD_WAIT lasts SRAM_LAT-1 cycles; never entered when SRAM_LAT is 1.
    assign w_wait_done = (r_wait == 2'(SRAM_LAT - 2));

    if (LSB_FIRST) begin : g_lsb_first
        assign w_cur_byte  = r_shift[7:0];
        assign w_shift_nxt = r_shift >> 8;
    end else begin : g_msb_first
        assign w_cur_byte  = r_shift[DATA_W-1 -: 8];
        assign w_shift_nxt = r_shift << 8;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        busy       = 1'b0;
        done       = 1'b0;
        csb_n      = 1'b1;
        we_n       = 1'b1;
        tx_valid   = 1'b0;
        tx_data_in = 8'h00;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = (word_count != '0) ? S_RD_REQ : S_FINISH;
                end
            end
            S_RD_REQ: begin
                busy   = 1'b1;
                csb_n  = 1'b0;
                w_next = (SRAM_LAT == 1) ? S_LOAD : S_RD_WAIT;
            end
            S_RD_WAIT: begin
                busy = 1'b1;
                if (w_wait_done) begin
                    w_next = S_LOAD;
                end
            end
            S_LOAD: begin
                busy   = 1'b1;
                w_next = S_SEND;
            end
            S_SEND: begin
                busy       = 1'b1;
                tx_valid   = 1'b1;
                tx_data_in = w_cur_byte;
                if (w_word_done) begin
                    w_next = (r_remain == c_ONE) ? S_FINISH : S_RD_REQ;
                end
            end
            S_FINISH: begin
                done   = !abort;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        // Abort outranks start in IDLE as well, so it is applied last.
        if (abort) begin
            w_next = S_IDLE;
        end
    end

    assign addr      = r_addr;
    assign tx_enable = busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr     <= '0;
            r_remain   <= '0;
            r_shift    <= '0;
            r_byte_idx <= '0;
            r_wait     <= '0;
        end else if (abort) begin
            r_addr     <= '0;
            r_remain   <= '0;
            r_shift    <= '0;
            r_byte_idx <= '0;
            r_wait     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && (word_count != '0)) begin
                        r_addr   <= base_addr;
                        r_remain <= word_count;
                    end
                end
                S_RD_REQ:  r_wait <= '0;
                S_RD_WAIT: r_wait <= r_wait + 2'd1;
                S_LOAD: begin
                    r_shift    <= sram_data_out;
                    r_byte_idx <= '0;
                end
                S_SEND: begin
                    if (w_xfer) begin
                        r_shift    <= w_shift_nxt;
                        r_byte_idx <= r_byte_idx + c_IDX_W'(1);
                        if (w_last_byte) begin
                            r_remain <= r_remain - c_ONE;
                            if (r_remain != c_ONE) begin
                                r_addr <= r_addr + ADDR_W'(1);
                            end
                        end
                    end
                end
                S_FINISH: r_addr <= '0;
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sram_uart_dumper.sv
// ============================================================================
// Module      : tb_sram_uart_dumper
// Description : Self-checking bench; two dumpers (LSB-first/LAT1, MSB-first/LAT2).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_uart_dumper;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        tx_ready = 1'b0;
    logic [4:0]  base_addr = '0;
    logic [5:0]  word_count = '0;

    logic [1:0]  busy, done, csb_n, we_n, tx_valid, tx_enable;
    logic [4:0]  addr [2];
    logic [7:0]  txd [2];
    logic [31:0] rdata [2];
    logic [31:0] pipe_b;
    logic [31:0] mem [32];

    always #5 clk = ~clk;

    sram_uart_dumper #(.ADDR_W(5), .DATA_W(32), .SRAM_LAT(1), .LSB_FIRST(1'b1)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .base_addr(base_addr), .word_count(word_count),
        .busy(busy[0]), .done(done[0]), .csb_n(csb_n[0]), .we_n(we_n[0]),
        .addr(addr[0]), .sram_data_out(rdata[0]), .tx_enable(tx_enable[0]),
        .tx_valid(tx_valid[0]), .tx_data_in(txd[0]), .tx_ready(tx_ready)
    );

    sram_uart_dumper #(.ADDR_W(5), .DATA_W(32), .SRAM_LAT(2), .LSB_FIRST(1'b0)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .base_addr(base_addr), .word_count(word_count),
        .busy(busy[1]), .done(done[1]), .csb_n(csb_n[1]), .we_n(we_n[1]),
        .addr(addr[1]), .sram_data_out(rdata[1]), .tx_enable(tx_enable[1]),
        .tx_valid(tx_valid[1]), .tx_data_in(txd[1]), .tx_ready(tx_ready)
    );

    // SRAM models: data only becomes valid after a real chip-select.
    always @(posedge clk) begin
        rdata[0] <= csb_n[0] ? 32'hBAD0BAD0 : mem[addr[0]];
        pipe_b   <= csb_n[1] ? 32'hBAD0BAD0 : mem[addr[1]];
        rdata[1] <= pipe_b;
    end

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor state
    logic [7:0] mb0[$], mb1[$];
    logic [4:0] ma0[$], ma1[$];
    int         cyc = 0;
    int         done_cnt[2], done_cyc[2], first_valid[2], first_busy[2], vseen[2];
    logic [1:0] prev_v = '0, prev_r = '0;
    logic [7:0] prev_d[2];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v = '0;
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (tx_valid[d] && tx_ready) begin
                    if (d == 0) mb0.push_back(txd[d]); else mb1.push_back(txd[d]);
                end
                if (!csb_n[d]) begin
                    if (d == 0) ma0.push_back(addr[d]); else ma1.push_back(addr[d]);
                end
                if (tx_valid[d]) begin
                    vseen[d]++;
                    if (first_valid[d] < 0) first_valid[d] = cyc;
                end
                if (busy[d] && first_busy[d] < 0) first_busy[d] = cyc;
                if (done[d]) begin
                    done_cnt[d]++;
                    done_cyc[d] = cyc;
                    chk("busy_low_at_done", {63'd0, busy[d]}, 64'd0);
                end
                if (prev_v[d] && !prev_r[d]) begin
                    chk("valid_held_in_stall", {63'd0, tx_valid[d]}, 64'd1);
                    chk("data_held_in_stall", {56'd0, txd[d]}, {56'd0, prev_d[d]});
                end
                chk("enable_eq_busy", {63'd0, tx_enable[d]}, {63'd0, busy[d]});
                chk("we_n_high", {63'd0, we_n[d]}, 64'd1);
                prev_v[d] = tx_valid[d];
                prev_r[d] = tx_ready;
                prev_d[d] = txd[d];
            end
        end
    end

    task automatic clear_mon();
        mb0.delete(); mb1.delete(); ma0.delete(); ma1.delete();
        done_cnt    = '{0, 0};
        done_cyc    = '{-1, -1};
        first_valid = '{-1, -1};
        first_busy  = '{-1, -1};
        vseen       = '{0, 0};
    endtask

    // Reference: a dump of cnt words from base sends mem[(base+w)%32] for each w,
    // bytes low-to-high on the LSB-first unit and high-to-low on the other.
    function automatic logic [7:0] ref_byte(input int base, input int idx, input bit lsb);
        logic [31:0] word;
        int          k;
        word = mem[(base + idx / 4) % 32];
        k    = idx % 4;
        return lsb ? 8'((word >> (8 * k)) & 32'hFF) : 8'((word >> (8 * (3 - k))) & 32'hFF);
    endfunction

    task automatic check_dump(input int base, input int cnt, input string tag);
        int bad0 = 0, bad1 = 0, abad0 = 0, abad1 = 0;
        chk({tag, "_nbytes_a"}, 64'(mb0.size()), 64'(cnt * 4));
        chk({tag, "_nbytes_b"}, 64'(mb1.size()), 64'(cnt * 4));
        chk({tag, "_nreads_a"}, 64'(ma0.size()), 64'(cnt));
        chk({tag, "_nreads_b"}, 64'(ma1.size()), 64'(cnt));
        for (int w = 0; w < cnt; w++) begin
            if (w < ma0.size() && ma0[w] !== 5'((base + w) % 32)) abad0++;
            if (w < ma1.size() && ma1[w] !== 5'((base + w) % 32)) abad1++;
        end
        for (int i = 0; i < cnt * 4; i++) begin
            if (i < mb0.size() && mb0[i] !== ref_byte(base, i, 1'b1)) bad0++;
            if (i < mb1.size() && mb1[i] !== ref_byte(base, i, 1'b0)) bad1++;
        end
        chk({tag, "_addr_order_a"}, 64'(abad0), 64'd0);
        chk({tag, "_addr_order_b"}, 64'(abad1), 64'd0);
        chk({tag, "_bytes_a"}, 64'(bad0), 64'd0);
        chk({tag, "_bytes_b"}, 64'(bad1), 64'd0);
        chk({tag, "_done_a"}, 64'(done_cnt[0]), 64'd1);
        chk({tag, "_done_b"}, 64'(done_cnt[1]), 64'd1);
    endtask

    // rdy_pct < 0 selects a 20-cycle stall once unit A is part-way through a word.
    task automatic run_dump(input int base, input int cnt, input int rdy_pct,
                            input string tag, output int t0);
        int k;
        int stall = 0;
        clear_mon();
        @(posedge clk); #1;
        base_addr  = 5'(base);
        word_count = 6'(cnt);
        start      = 1'b1;
        tx_ready   = 1'b1;
        t0         = cyc;
        @(posedge clk); #1;
        start      = 1'b0;
        base_addr  = 5'($urandom);
        word_count = 6'($urandom);
        for (k = 0; k < 3000; k++) begin
            if (done_cnt[0] > 0 && done_cnt[1] > 0) break;
            if (rdy_pct < 0) begin
                if (mb0.size() >= 2 && stall < 20) begin
                    tx_ready = 1'b0;
                    stall++;
                end else begin
                    tx_ready = 1'b1;
                end
            end else begin
                tx_ready = ($urandom_range(99) < rdy_pct);
            end
            @(posedge clk); #1;
        end
        chk({tag, "_timeout"}, 64'(k < 3000), 64'd1);
        tx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_dump(base, cnt, tag);
    endtask

    typedef struct {
        int base;
        int cnt;
        int rdy_pct;
        int exp_bytes;
    } vec_t;

    vec_t vt[5];

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"},     {62'd0, busy},      64'd0);
        chk({tag, "_done"},     {62'd0, done},      64'd0);
        chk({tag, "_csb_n"},    {62'd0, csb_n},     64'd3);
        chk({tag, "_we_n"},     {62'd0, we_n},      64'd3);
        chk({tag, "_tx_valid"}, {62'd0, tx_valid},  64'd0);
        chk({tag, "_tx_en"},    {62'd0, tx_enable}, 64'd0);
        chk({tag, "_addr"},     {54'd0, addr[1], addr[0]}, 64'd0);
        chk({tag, "_txd"},      {48'd0, txd[1], txd[0]},   64'd0);
    endtask

    initial begin
        int t0;
        int bad;
        int k;

        vt[0] = '{3, 1, 100, 4};
        vt[1] = '{30, 4, 100, 16};
        vt[2] = '{0, 0, 100, 0};
        vt[3] = '{7, 32, 70, 128};
        vt[4] = '{31, 2, -1, 8};

        for (int i = 0; i < 32; i++) mem[i] = $urandom;
        mem[3] = 32'hDEADBEEF;

        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst_n = 1'b1;

        for (int v = 0; v < 5; v++) begin
            string tag;
            tag = $sformatf("vec%0d", v);
            run_dump(vt[v].base, vt[v].cnt, vt[v].rdy_pct, tag, t0);
            chk({tag, "_exp_bytes"}, 64'(mb0.size()), 64'(vt[v].exp_bytes));
            if (vt[v].cnt > 0) begin
                chk({tag, "_busy_lat"},  64'(first_busy[0] - t0),  64'd1);
                chk({tag, "_valid_lat_a"}, 64'(first_valid[0] - t0), 64'd3);
                chk({tag, "_valid_lat_b"}, 64'(first_valid[1] - t0), 64'd4);
            end else begin
                // done lands in the cycle right after the start cycle (start cycle is the first)
                chk({tag, "_done_lat_a"}, 64'(done_cyc[0] - t0), 64'd1);
                chk({tag, "_done_lat_b"}, 64'(done_cyc[1] - t0), 64'd1);
                chk({tag, "_no_valid"},   64'(vseen[0] + vseen[1]), 64'd0);
                chk({tag, "_no_busy"},    64'(first_busy[0] + first_busy[1]), -64'sd2);
            end
            if (v == 0) begin
                chk("deadbeef_lsb_first",
                    (mb0.size() == 4) ? {32'd0, mb0[0], mb0[1], mb0[2], mb0[3]} : 64'hFFFF,
                    64'hEFBEADDE);
                chk("deadbeef_msb_first",
                    (mb1.size() == 4) ? {32'd0, mb1[0], mb1[1], mb1[2], mb1[3]} : 64'hFFFF,
                    64'hDEADBEEF);
            end
        end

        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < 32; i++) mem[i] = $urandom;
            run_dump($urandom_range(31), $urandom_range(32, 1), $urandom_range(100, 40),
                     $sformatf("rand%0d", r), t0);
        end

        // Abort in the middle of the second word
        clear_mon();
        @(posedge clk); #1;
        base_addr = 5'd5; word_count = 6'd3; start = 1'b1; tx_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (k = 0; k < 500 && mb0.size() < 6; k++) begin
            @(posedge clk); #1;
        end
        chk("abort_reach_word2", 64'(mb0.size() >= 6), 64'd1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check_idle_outputs("abort");
        repeat (5) @(posedge clk);
        #1;
        chk("abort_no_done", 64'(done_cnt[0] + done_cnt[1]), 64'd0);
        chk("abort_bytes_sent_a", 64'(mb0.size()), 64'd7);
        bad = 0;
        for (int i = 0; i < mb0.size(); i++) if (mb0[i] !== ref_byte(5, i, 1'b1)) bad++;
        for (int i = 0; i < mb1.size(); i++) if (mb1[i] !== ref_byte(5, i, 1'b0)) bad++;
        chk("abort_prefix", 64'(bad), 64'd0);

        // Abort and start together in IDLE: start must be dropped
        clear_mon();
        @(posedge clk); #1;
        base_addr = 5'd1; word_count = 6'd2; start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("abort_start_no_busy", 64'(first_busy[0] + first_busy[1]), -64'sd2);
        chk("abort_start_no_reads", 64'(ma0.size() + ma1.size()), 64'd0);
        chk("abort_start_no_done", 64'(done_cnt[0] + done_cnt[1]), 64'd0);

        run_dump(10, 2, 100, "post_abort", t0);

        // Reset asserted mid-SEND
        clear_mon();
        @(posedge clk); #1;
        base_addr = 5'd9; word_count = 6'd2; start = 1'b1; tx_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (k = 0; k < 100 && !tx_valid[0]; k++) begin
            @(posedge clk); #1;
        end
        chk("rst_reach_send", {63'd0, tx_valid[0]}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midrst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_dump(28, 5, 60, "post_reset", t0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
